// File: rtl/alu_serial_sequencer.sv
// -----------------------------------------------------------------------------
// alu_serial_sequencer
//
// Drives a purely combinational 1-bit ALU one bit per clock, LSB first, to
// perform a WIDTH-bit ADD / SUB / AND / NOR / XOR. The carry or borrow chain
// is held in a register between bits. Each ALU result bit is shifted into the
// result register from the MSB side. Completion is flagged with a one-cycle
// done pulse.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   start           request a new operation (accepted in IDLE or DONE)
//   op              3-bit opcode: 000 ADD, 001 SUB, 010 AND, 011 NOR, 111 XOR
//   a, b            WIDTH-bit operands, captured when start is accepted
//   busy            high while bits are being processed
//   done            one-cycle pulse when result/carry_flag become valid
//   result          assembled result, held until the next accepted start
//   carry_flag      final carry (ADD) or borrow (SUB), otherwise 0
//   alu_a0, alu_b0  current operand bits to the ALU
//   alu_c_in        chain input to the ALU (carry for ADD, borrow for SUB)
//   alu_b_in        borrow input to the ALU (SUB only)
//   alu_sel         opcode to the ALU
//   alu_y           ALU result bit
//   alu_c_out       ALU carry out
//   alu_b_out       ALU borrow out
// -----------------------------------------------------------------------------
module alu_serial_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             alu_a0,
    output logic             alu_b0,
    output logic             alu_c_in,
    output logic             alu_b_in,
    output logic [2:0]       alu_sel,
    input  logic             alu_y,
    input  logic             alu_c_out,
    input  logic             alu_b_out
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [2:0]       OP_ADD   = 3'b000;
    localparam logic [2:0]       OP_SUB   = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [2:0]       op_reg;
    logic             chain;
    logic [CNT_W-1:0] cnt;
    logic             chain_next;
    logic             running;

    assign running = (state == S_RUN);

    // Next chain value: carry for ADD, borrow for SUB, nothing for the
    // bitwise and undefined opcodes, so the chain stays 0 for those.
    always_comb begin
        chain_next = 1'b0;
        case (op_reg)
            OP_ADD:  chain_next = alu_c_out;
            OP_SUB:  chain_next = alu_b_out;
            default: chain_next = 1'b0;
        endcase
    end

    // ALU drive is gated by RUN so the ALU sees all zeros in IDLE, DONE and
    // during reset. For SUB the ALU forms the difference bit from c_in and the
    // borrow from b_in, so the same chain bit feeds both.
    assign alu_a0   = running & a_sh[0];
    assign alu_b0   = running & b_sh[0];
    assign alu_sel  = running ? op_reg : 3'b000;
    assign alu_c_in = running & chain & ((op_reg == OP_ADD) | (op_reg == OP_SUB));
    assign alu_b_in = running & chain & (op_reg == OP_SUB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            carry_flag <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            op_reg     <= 3'b000;
            chain      <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                // DONE behaves like IDLE except that done is high for this one
                // cycle; a start here launches the next operation immediately.
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= S_RUN;
                        busy   <= 1'b1;
                        a_sh   <= a;
                        b_sh   <= b;
                        op_reg <= op;
                        chain  <= 1'b0;
                        cnt    <= '0;
                        result <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                // One bit per cycle; start is ignored here.
                S_RUN: begin
                    result <= {alu_y, result[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    chain  <= chain_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        carry_flag <= chain_next;
                        cnt        <= '0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
